ball_engine: RTL and testbench
==============================

# ball_engine

Parameterised successor to the fixed-size ball controller for the VGA Pong game. It runs one ball per instance with configurable size, playfield, colour and speed. On every frame tick it moves the ball, bounces it off the top and bottom walls, and bounces it off either paddle with a speed-up. When the ball leaves the playfield on the left or right it reports a miss and re-serves from the centre after a programmable pause. It sits between the VGA timing generator (x, y, vsync) and the paddle/score logic.

## Interface
Parameters:
- WIDTH, 20: ball width in pixels.
- HEIGHT, 20: ball height in pixels.
- SCR_W, 640: playfield width; x range 0..SCR_W-1.
- SCR_H, 480: playfield height; y range 0..SCR_H-1.
- COLOR, 3'b110: RGB drawn where the ball is.
- XSPEED_INIT, 4: horizontal pixels/frame after a serve.
- XSPEED_MAX, 12: horizontal speed cap, ≤ 15.
- SPEEDUP, 1: speed added per paddle hit.
- YSPEED, 4: vertical pixels/frame.
- SERVE_FRAMES, 60: frames held at centre before the ball moves.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- vsync  in  1  vertical sync, active high.
- paddlehit  in  1  a paddle is drawn at (x,y).
- pause  in  1  freeze motion; the collision latch still works.
- color  out  3  COLOR when ballhit, else 0.
- ballhit  out  1  ball covers (x,y), combinational.
- collision  out  1  pending paddle collision, registered.
- miss_left  out  1  one-cycle pulse: ball exited the left edge.
- miss_right  out  1  one-cycle pulse: ball exited the right edge.
- serving  out  1  high while in SERVE.

## Operation
- **Hit detection:** ballhit = (xpos ≤ x < xpos+WIDTH) && (ypos ≤ y < ypos+HEIGHT). Compare in 11 bits so the upper bound does not overflow.
- **Frame tick:** vsync is registered into vsync_q. tick = vsync_q & ~vsync, i.e. the first cycle after vsync falls.
- **Collision latch:** set when ballhit && paddlehit in any cycle. Cleared only when a PLAY tick consumes it.
- **State SERVE:**
  - Ball held at xpos=(SCR_W-WIDTH)/2, ypos=(SCR_H-HEIGHT)/2.
  - Each tick with pause=0 decrements serve_cnt.
  - A tick with serve_cnt==1 moves to PLAY. Position is unchanged on that tick.
  - Collisions latched during SERVE are discarded on entry to PLAY.
- **State PLAY, each tick with pause=0, in this order:**
  1. If collision is set:
     - xdir = 1 if xpos+WIDTH/2 < SCR_W/2, else xdir = 0.
     - speed = min(speed+SPEEDUP, XSPEED_MAX).
     - Clear collision.
  2. Vertical move:
     - ydir=0 and ypos < YSPEED: ypos=0, ydir=1.
     - ydir=1 and ypos+HEIGHT+YSPEED > SCR_H: ypos=SCR_H-HEIGHT, ydir=0.
     - Otherwise ypos ± YSPEED.
  3. Horizontal move:
     - xdir=0 and xpos < speed: pulse miss_left and enter MISS.
     - xdir=1 and xpos+WIDTH+speed > SCR_W: pulse miss_right and enter MISS.
     - Otherwise xpos ± speed.
- **State MISS (one cycle):**
  - Centre the ball and set speed=XSPEED_INIT.
  - xdir = 0 after miss_left, 1 after miss_right (serve toward the side that missed).
  - Set ydir = ~ydir, serve_cnt=SERVE_FRAMES, collision=0.
  - Go to SERVE.
- **Reset:** as if leaving MISS, except xdir=1 and ydir=0. State=SERVE.

## Timing
- All state is updated on posedge clk and cleared asynchronously by rst low. Reset may occur mid-frame or mid-serve with no residue.
- Reset values:
  - collision=0, miss_left=0, miss_right=0, serving=1.
  - color and ballhit follow the centred position.
- Latency:
  - Position updates in the cycle after tick is detected, i.e. 2 clk after vsync falls.
  - miss_* rises in that same cycle and is high for exactly 1 clk.
  - serving drops in the same cycle as the SERVE→PLAY transition.
- Simultaneous events:
  - A collision and an edge exit on the same tick: the collision is applied first, so the ball reflects instead of missing.
  - Wall and paddle on the same tick are handled independently.
- Pause: ticks are ignored entirely. serve_cnt, position and speed hold. The collision latch may still set.
- Arithmetic: xpos and ypos are 10 bits, speed is 4 bits, and all compares are 11 bits unsigned. Positions never wrap.

## Test plan
- **Reset and serve:** release rst, run 60 ticks → xpos=310, ypos=230, serving=1 until tick 60. The next tick gives xpos=314, ypos=226.
- **Top wall:** ypos=2, ydir=0 at a tick → ypos=0, ydir=1. Next tick → ypos=4.
- **Paddle bounce:** force paddlehit while ballhit with xpos=600, xdir=1 → next tick xdir=0, speed 4→5, xpos=595, collision cleared. Ten further hits saturate speed at 12.
- **Miss:** xdir=1, xpos=617, speed=4, no paddle → miss_right pulses for 1 clk. Ball returns to (310,230), serving=1, speed=4, xdir=1.
- **Priority:** collision latched and xpos=2, xdir=0 on the same tick → no miss_left, xdir=1, xpos=7.
- **Pause:** pause=1 across 5 ticks during PLAY → position unchanged, collision latch still sets. Resume → motion continues.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine
// One Pong ball: moves once per frame, bounces off the top/bottom walls and
// off paddles (with speed-up), reports left/right misses and re-serves from
// the centre after a pause of SERVE_FRAMES frames.
//
// Ports:
//   clk        pixel clock
//   rst        asynchronous, active-low reset
//   x, y       current pixel column/row from the VGA timing generator
//   vsync      vertical sync, active high; its falling edge marks a frame
//   paddlehit  a paddle is being drawn at (x,y)
//   pause      freeze motion; the collision latch still works
//   color      COLOR while ballhit, else 0
//   ballhit    ball covers (x,y), combinational
//   collision  pending paddle collision, registered
//   miss_left  one-cycle pulse: ball left the playfield on the left
//   miss_right one-cycle pulse: ball left the playfield on the right
//   serving    high while the ball is held at the centre
//   dbg_state  FSM state (0 SERVE, 1 PLAY, 2 MISS)
//   dbg_xpos, dbg_ypos, dbg_speed  ball position and horizontal speed
//
// Timing contract: vsync falling is registered twice (vsync_q, then tick),
// so all motion happens on the clock edge two cycles after vsync falls.
// miss_* are raised on that edge and dropped on the next (the MISS cycle).
module ball_engine #(
  parameter int         WIDTH        = 20,
  parameter int         HEIGHT       = 20,
  parameter int         SCR_W        = 640,
  parameter int         SCR_H        = 480,
  parameter logic [2:0] COLOR        = 3'b110,
  parameter int         XSPEED_INIT  = 4,
  parameter int         XSPEED_MAX   = 12,
  parameter int         SPEEDUP      = 1,
  parameter int         YSPEED       = 4,
  parameter int         SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vsync,
  input  logic       paddlehit,
  input  logic       pause,
  output logic [2:0] color,
  output logic       ballhit,
  output logic       collision,
  output logic       miss_left,
  output logic       miss_right,
  output logic       serving,
  output logic [1:0] dbg_state,
  output logic [9:0] dbg_xpos,
  output logic [9:0] dbg_ypos,
  output logic [3:0] dbg_speed
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]       X_CTR     = 10'((SCR_W - WIDTH) / 2);
  localparam logic [9:0]       Y_CTR     = 10'((SCR_H - HEIGHT) / 2);
  localparam logic [10:0]      W11       = 11'(WIDTH);
  localparam logic [10:0]      H11       = 11'(HEIGHT);
  localparam logic [10:0]      SW11      = 11'(SCR_W);
  localparam logic [10:0]      SH11      = 11'(SCR_H);
  localparam logic [10:0]      YS11      = 11'(YSPEED);
  localparam logic [9:0]       YS10      = 10'(YSPEED);
  localparam logic [10:0]      HALF_W11  = 11'(WIDTH / 2);
  localparam logic [10:0]      HALF_SW11 = 11'(SCR_W / 2);
  localparam logic [3:0]       SP_INIT   = 4'(XSPEED_INIT);
  localparam logic [4:0]       SP_MAX5   = 5'(XSPEED_MAX);
  localparam logic [4:0]       SP_UP5    = 5'(SPEEDUP);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_MISS  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_xpos, w_xpos_nxt;
  logic [9:0]       r_ypos, w_ypos_nxt;
  logic             r_xdir, w_xdir_nxt;   // 1 = moving right
  logic             r_ydir, w_ydir_nxt;   // 1 = moving down
  logic [3:0]       r_speed, w_speed_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_col, w_col_nxt;
  logic             r_miss_l, w_miss_l_nxt;
  logic             r_miss_r, w_miss_r_nxt;
  logic             r_vsync_q;
  logic             r_tick;

  logic [10:0] w_x11, w_y11, w_xpos11, w_ypos11;
  logic        w_hit;
  logic        w_pad_hit;
  logic        w_go;
  logic        w_xdir_eff;
  logic [3:0]  w_speed_eff;
  logic [4:0]  w_sp_sum;

  // All position compares are done in 11 bits so pos+size never overflows.
  assign w_x11    = {1'b0, x};
  assign w_y11    = {1'b0, y};
  assign w_xpos11 = {1'b0, r_xpos};
  assign w_ypos11 = {1'b0, r_ypos};

  assign w_hit = (w_x11 >= w_xpos11) && (w_x11 < w_xpos11 + W11) &&
                 (w_y11 >= w_ypos11) && (w_y11 < w_ypos11 + H11);

  assign w_pad_hit = w_hit & paddlehit;
  assign w_go      = r_tick & ~pause;

  assign ballhit    = w_hit;
  assign color      = w_hit ? COLOR : 3'b000;
  assign collision  = r_col;
  assign miss_left  = r_miss_l;
  assign miss_right = r_miss_r;
  assign serving    = (r_state == S_SERVE);
  assign dbg_state  = r_state;
  assign dbg_xpos   = r_xpos;
  assign dbg_ypos   = r_ypos;
  assign dbg_speed  = r_speed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_SERVE;
      r_xpos    <= X_CTR;
      r_ypos    <= Y_CTR;
      r_xdir    <= 1'b1;
      r_ydir    <= 1'b0;
      r_speed   <= SP_INIT;
      r_cnt     <= CNT_INIT;
      r_col     <= 1'b0;
      r_miss_l  <= 1'b0;
      r_miss_r  <= 1'b0;
      r_vsync_q <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_xpos    <= w_xpos_nxt;
      r_ypos    <= w_ypos_nxt;
      r_xdir    <= w_xdir_nxt;
      r_ydir    <= w_ydir_nxt;
      r_speed   <= w_speed_nxt;
      r_cnt     <= w_cnt_nxt;
      r_col     <= w_col_nxt;
      r_miss_l  <= w_miss_l_nxt;
      r_miss_r  <= w_miss_r_nxt;
      r_vsync_q <= vsync;
      r_tick    <= r_vsync_q & ~vsync;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_xpos_nxt   = r_xpos;
    w_ypos_nxt   = r_ypos;
    w_xdir_nxt   = r_xdir;
    w_ydir_nxt   = r_ydir;
    w_speed_nxt  = r_speed;
    w_cnt_nxt    = r_cnt;
    w_col_nxt    = r_col | w_pad_hit;
    w_miss_l_nxt = 1'b0;
    w_miss_r_nxt = 1'b0;
    w_xdir_eff   = r_xdir;
    w_speed_eff  = r_speed;
    w_sp_sum     = {1'b0, r_speed} + SP_UP5;

    case (r_state)
      S_SERVE: begin
        if (w_go) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_PLAY;
            // Hits latched while waiting at the centre are stale.
            w_col_nxt   = w_pad_hit;
          end
        end
      end

      S_PLAY: begin
        if (w_go) begin
          // Paddle first, so a reflection beats a miss on the same frame.
          if (r_col) begin
            w_xdir_eff  = (w_xpos11 + HALF_W11 < HALF_SW11);
            w_speed_eff = (w_sp_sum > SP_MAX5) ? SP_MAX5[3:0] : w_sp_sum[3:0];
            w_col_nxt   = w_pad_hit;
          end
          w_xdir_nxt  = w_xdir_eff;
          w_speed_nxt = w_speed_eff;

          if (!r_ydir && (w_ypos11 < YS11)) begin
            w_ypos_nxt = 10'd0;
            w_ydir_nxt = 1'b1;
          end else if (r_ydir && (w_ypos11 + H11 + YS11 > SH11)) begin
            w_ypos_nxt = 10'(SCR_H - HEIGHT);
            w_ydir_nxt = 1'b0;
          end else if (r_ydir) begin
            w_ypos_nxt = r_ypos + YS10;
          end else begin
            w_ypos_nxt = r_ypos - YS10;
          end

          if (!w_xdir_eff && (w_xpos11 < {7'd0, w_speed_eff})) begin
            w_miss_l_nxt = 1'b1;
            w_state_nxt  = S_MISS;
          end else if (w_xdir_eff &&
                       (w_xpos11 + W11 + {7'd0, w_speed_eff} > SW11)) begin
            w_miss_r_nxt = 1'b1;
            w_state_nxt  = S_MISS;
          end else if (w_xdir_eff) begin
            w_xpos_nxt = r_xpos + {6'd0, w_speed_eff};
          end else begin
            w_xpos_nxt = r_xpos - {6'd0, w_speed_eff};
          end
        end
      end

      S_MISS: begin
        // Serve toward the side that missed; miss_r is still high here.
        w_xpos_nxt  = X_CTR;
        w_ypos_nxt  = Y_CTR;
        w_speed_nxt = SP_INIT;
        w_xdir_nxt  = r_miss_r;
        w_ydir_nxt  = ~r_ydir;
        w_cnt_nxt   = CNT_INIT;
        w_col_nxt   = 1'b0;
        w_state_nxt = S_SERVE;
      end

      default: begin
        w_state_nxt = S_SERVE;
      end
    endcase
  end

endmodule

// File: tb/tb_ball_engine.sv
`timescale 1ns/1ps
module tb_ball_engine;

  localparam int         W   = 20;
  localparam int         H   = 20;
  localparam int         SW  = 640;
  localparam int         SH  = 480;
  localparam logic [2:0] COL = 3'b110;
  localparam int         XI  = 4;
  localparam int         XM  = 12;
  localparam int         SU  = 1;
  localparam int         YS  = 4;
  localparam int         SF  = 60;
  localparam int         XC  = (SW - W) / 2;
  localparam int         YC  = (SH - H) / 2;
  localparam int         N_FRAMES = 900;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       vsync = 1'b0;
  logic       paddlehit = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] color;
  logic       ballhit, collision, miss_left, miss_right, serving;
  logic [1:0] dbg_state;
  logic [9:0] dbg_xpos, dbg_ypos;
  logic [3:0] dbg_speed;

  always #5 clk = ~clk;

  ball_engine #(
    .WIDTH(W), .HEIGHT(H), .SCR_W(SW), .SCR_H(SH), .COLOR(COL),
    .XSPEED_INIT(XI), .XSPEED_MAX(XM), .SPEEDUP(SU), .YSPEED(YS),
    .SERVE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .vsync(vsync),
    .paddlehit(paddlehit), .pause(pause), .color(color),
    .ballhit(ballhit), .collision(collision), .miss_left(miss_left),
    .miss_right(miss_right), .serving(serving), .dbg_state(dbg_state),
    .dbg_xpos(dbg_xpos), .dbg_ypos(dbg_ypos), .dbg_speed(dbg_speed)
  );

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_miss_l = 0;
  int n_miss_r = 0;
  int n_pads   = 0;

  typedef struct packed {
    logic       ml;
    logic       mr;
    logic       sv_c;   // serving right after the tick edge
    logic       sv;     // serving once the frame has settled
    logic       col;
    logic       hit;
    logic [3:0] sp;
    logic [9:0] xp;
    logic [9:0] yp;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int m_x, m_y, m_speed, m_cnt;
  bit m_xdir, m_ydir, m_col, m_serve;

  function automatic void model_reset();
    m_x = XC; m_y = YC; m_xdir = 1'b1; m_ydir = 1'b0;
    m_speed = XI; m_cnt = SF; m_col = 1'b0; m_serve = 1'b1;
  endfunction

  function automatic bit model_covers(input int px, input int py);
    return (px >= m_x) && (px < m_x + W) && (py >= m_y) && (py < m_y + H);
  endfunction

  // One frame tick: returns which side (if any) was missed.
  task automatic model_tick(input bit p, output bit ml, output bit mr);
    ml = 1'b0;
    mr = 1'b0;
    if (p) return;
    if (m_serve) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_serve = 1'b0;
        m_col   = 1'b0;
      end
      return;
    end
    if (m_col) begin
      m_xdir  = (m_x + W / 2 < SW / 2);
      m_speed = (m_speed + SU > XM) ? XM : m_speed + SU;
      m_col   = 1'b0;
    end
    if (!m_ydir && m_y < YS) begin
      m_y = 0; m_ydir = 1'b1;
    end else if (m_ydir && m_y + H + YS > SH) begin
      m_y = SH - H; m_ydir = 1'b0;
    end else begin
      m_y = m_ydir ? m_y + YS : m_y - YS;
    end
    if (!m_xdir && m_x < m_speed)               ml = 1'b1;
    else if (m_xdir && m_x + W + m_speed > SW)  mr = 1'b1;
    else m_x = m_xdir ? m_x + m_speed : m_x - m_speed;
    if (ml || mr) begin
      m_x = XC; m_y = YC; m_speed = XI; m_xdir = mr; m_ydir = !m_ydir;
      m_cnt = SF; m_col = 1'b0; m_serve = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_frame(input bit do_pad, input bit p);
    bit   ml, mr, svc;
    int   px, py;
    exp_t e;
    if (do_pad) begin
      x = 10'(m_x + $urandom_range(0, W - 1));
      y = 10'(m_y + $urandom_range(0, H - 1));
      paddlehit = 1'b1;
      @(posedge clk); #1;
      paddlehit = 1'b0;
      m_col = 1'b1;
      n_pads++;
    end
    pause = p;
    model_tick(p, ml, mr);
    svc = (ml || mr) ? 1'b0 : m_serve;
    if (ml) n_miss_l++;
    if (mr) n_miss_r++;
    if ($urandom_range(0, 1) == 1) begin
      px = m_x - 1 + $urandom_range(0, W + 1);
      py = m_y - 1 + $urandom_range(0, H + 1);
      if (px < 0) px = 0;
      if (py < 0) py = 0;
    end else begin
      px = $urandom_range(0, SW - 1);
      py = $urandom_range(0, SH - 1);
    end
    x = 10'(px);
    y = 10'(py);
    e.ml = ml; e.mr = mr; e.sv_c = svc; e.sv = m_serve; e.col = m_col;
    e.hit = model_covers(px, py); e.sp = 4'(m_speed);
    e.xp = 10'(m_x); e.yp = 10'(m_y);
    exp_q.push_back(e);
    vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_xpos"}, dbg_xpos, XC);
    chk({tag, "_ypos"}, dbg_ypos, YC);
    chk({tag, "_serving"}, serving, 1);
    chk({tag, "_collision"}, collision, 0);
    chk({tag, "_miss_left"}, miss_left, 0);
    chk({tag, "_miss_right"}, miss_right, 0);
    chk({tag, "_speed"}, dbg_speed, XI);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_values("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge vsync);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_expectation: vsync fell with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        @(posedge clk);
        @(posedge clk); #1;
        chk("miss_left", miss_left, e.ml);
        chk("miss_right", miss_right, e.mr);
        chk("serving_at_tick", serving, e.sv_c);
        @(posedge clk); #1;
        chk("miss_left_width", miss_left, 0);
        chk("miss_right_width", miss_right, 0);
        chk("xpos", dbg_xpos, e.xp);
        chk("ypos", dbg_ypos, e.yp);
        chk("speed", dbg_speed, e.sp);
        chk("serving", serving, e.sv);
        chk("collision", collision, e.col);
        chk("ballhit", ballhit, e.hit);
        chk("color", color, e.hit ? COL : 3'b000);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit do_pad, p;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    x = 10'(XC); y = 10'(YC); #1;
    chk("reset_hit_corner", ballhit, 1);
    chk("reset_color", color, COL);
    x = 10'(XC + W - 1); y = 10'(YC + H - 1); #1;
    chk("reset_hit_far_corner", ballhit, 1);
    x = 10'(XC + W); #1;
    chk("reset_hit_right_edge", ballhit, 0);
    chk("reset_color_off", color, 0);
    x = 10'(XC); y = 10'(YC + H); #1;
    chk("reset_hit_bottom_edge", ballhit, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int f = 0; f < N_FRAMES; f++) begin
      if (f == 450 || f == 470) do_reset();
      if (f <= SF) begin
        do_pad = 1'b0;
        p      = 1'b0;
      end else begin
        p = ($urandom_range(0, 9) == 0);
        if (m_serve)
          do_pad = ($urandom_range(0, 19) == 0);
        else if (m_x < 10 || m_x + W > SW - 10)
          do_pad = ($urandom_range(0, 1) == 0);
        else
          do_pad = ($urandom_range(0, 11) == 0);
      end
      run_frame(do_pad, p);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("info: paddle_hits=%0d left_misses=%0d right_misses=%0d",
             n_pads, n_miss_l, n_miss_r);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
